program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter WIDTH, default 8: PC and TARGET width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries, power of two, 2..16.
REQ-003 CLK  input  1  Clock. The block is rising-edge triggered on CLK and uses no other clock.
REQ-004 RESET  input  1  Synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 EN  input  1  Advance enable. While low, all state holds.
REQ-006 JUMP  input  1  Load TARGET into PC.
REQ-007 CALL  input  1  Push return address, then load TARGET.
REQ-008 RET  input  1  Pop the return stack into PC.
REQ-009 TARGET  input  WIDTH  Jump/call destination.
REQ-010 PC  output  WIDTH  Current program counter, registered.
REQ-011 FULL  output  1  Return stack holds DEPTH entries.
REQ-012 EMPTY  output  1  Return stack holds 0 entries.
REQ-013 OVERFLOW  output  1  Sticky: a CALL was attempted while FULL.
REQ-014 UNDERFLOW  output  1  Sticky: a RET was attempted while EMPTY.

Function
REQ-015 All state changes occur on the rising CLK edge; outputs are registered and reflect a command one cycle after it is sampled.
REQ-016 Command priority when EN=1: RET > CALL > JUMP > increment. Lower-priority lines asserted in the same cycle are ignored.
REQ-017 Increment (EN=1, no command): PC <= PC+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-018 JUMP: PC <= TARGET; the stack is unchanged.
REQ-019 CALL when not FULL: push (PC+1) mod 2^WIDTH; PC <= TARGET; depth +1.
REQ-020 CALL when FULL: no push; PC holds; OVERFLOW <= 1.
REQ-021 RET when not EMPTY: PC <= top entry; depth -1.
REQ-022 RET when EMPTY: PC holds; UNDERFLOW <= 1.
REQ-023 EN=0: PC, stack, depth and flags hold regardless of the command lines.
REQ-024 FULL and EMPTY are derived from a registered depth count (0..DEPTH).
REQ-025 FULL and EMPTY are never both 1.
REQ-026 OVERFLOW and UNDERFLOW clear only on RESET.
REQ-027 The stack is LIFO; entries beyond the current depth are don't-care and are never observable on PC.

Reset
REQ-028 With RESET=1 at a rising edge, the next state is: PC=0, depth=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0.
REQ-029 RESET overrides EN and all commands, including a CALL or RET issued in the same cycle.
REQ-030 After RESET, prior stack contents are unreachable.

Configuration
REQ-031 Macro RETURN_STACK_EN: when defined, the return stack and REQ-019..REQ-022 are implemented.
REQ-032 When RETURN_STACK_EN is undefined, no stack storage is built:
  - CALL behaves exactly as JUMP.
  - RET is ignored, so the cycle is an increment if EN=1.
  - FULL=0, EMPTY=1, OVERFLOW=0 and UNDERFLOW=0 are held constant.
REQ-033 The port list is identical with and without RETURN_STACK_EN.

Verification
REQ-034 RESET, then EN=1 for 3 cycles -> PC = 1, 2, 3; EMPTY=1.
REQ-035 PC=0x10, CALL with TARGET=0x80 -> PC=0x80; then RET -> PC=0x11, EMPTY=1.
REQ-036 DEPTH=4: five CALLs to 0x20 -> FULL=1 after the 4th; the 5th leaves PC=0x20 and sets OVERFLOW=1; four RETs then return PC in LIFO order.
REQ-037 Fresh reset, RET -> PC=0, UNDERFLOW=1; an increment follows -> PC=1, UNDERFLOW still 1.
REQ-038 PC=0xFF, EN=1 -> PC=0x00. Same cycle JUMP=1, CALL=1, RET=1 with the stack empty -> RET wins: PC holds, UNDERFLOW=1.
REQ-039 Mid-sequence RESET with CALL=1 and depth=2 -> PC=0, EMPTY=1, flags 0.

Source files
------------

// File: rtl/program_counter.sv
// Program counter with jump, call/return and an optional LIFO return stack.
// Define RETURN_STACK_EN to build the return stack; without it CALL acts as JUMP and RET is ignored.
module program_counter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             JUMP,
  input  logic             CALL,
  input  logic             RET,
  input  logic [WIDTH-1:0] TARGET,
  output logic [WIDTH-1:0] PC,
  output logic             FULL,
  output logic             EMPTY,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + WIDTH'(1);
  assign PC     = pc_q;

`ifdef RETURN_STACK_EN
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [PTR_W:0]   depth_q;
  logic             full_int;
  logic             empty_int;
  logic             overflow_q;
  logic             underflow_q;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] top_idx;
  logic             do_push;

  assign full_int  = (depth_q == (PTR_W+1)'(DEPTH));
  assign empty_int = (depth_q == '0);
  assign push_idx  = depth_q[PTR_W-1:0];
  assign top_idx   = PTR_W'(depth_q - (PTR_W+1)'(1));
  assign do_push   = !RESET && EN && !RET && CALL && !full_int;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q        <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (EN) begin
      if (RET) begin
        if (empty_int) begin
          underflow_q <= 1'b1;
        end else begin
          pc_q    <= stack_mem[top_idx];
          depth_q <= depth_q - (PTR_W+1)'(1);
        end
      end else if (CALL) begin
        if (full_int) begin
          overflow_q <= 1'b1;
        end else begin
          pc_q    <= TARGET;
          depth_q <= depth_q + (PTR_W+1)'(1);
        end
      end else if (JUMP) begin
        pc_q <= TARGET;
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  // Storage needs no reset: entries above depth_q are never read.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign FULL      = full_int;
  assign EMPTY     = empty_int;
  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;
`else
  logic unused_ret;

  assign unused_ret = RET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= '0;
    end else if (EN) begin
      if (CALL || JUMP) begin
        pc_q <= TARGET;
      end else begin
        pc_q <= pc_inc;
      end
    end
  end

  assign FULL      = 1'b0;
  assign EMPTY     = 1'b1;
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios then randomized traffic
// compared against a queue-based reference model (follows RETURN_STACK_EN if defined).
module tb_program_counter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef RETURN_STACK_EN
  localparam bit HAS_STACK = 1'b1;
`else
  localparam bit HAS_STACK = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic             EN;
  logic             JUMP;
  logic             CALL;
  logic             RET;
  logic [WIDTH-1:0] TARGET;
  logic [WIDTH-1:0] PC;
  logic             FULL;
  logic             EMPTY;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .JUMP(JUMP), .CALL(CALL), .RET(RET),
    .TARGET(TARGET), .PC(PC), .FULL(FULL), .EMPTY(EMPTY),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_pc  = 0;
  int m_stack[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},        int'(PC),        m_pc);
    check({tag, ".full"},      int'(FULL),      int'(HAS_STACK && m_stack.size() == DEPTH));
    check({tag, ".empty"},     int'(EMPTY),     int'(m_stack.size() == 0));
    check({tag, ".overflow"},  int'(OVERFLOW),  int'(m_ovf));
    check({tag, ".underflow"}, int'(UNDERFLOW), int'(m_unf));
  endtask

  task automatic model_step(input bit rst, input bit en, input bit j, input bit c,
                            input bit r, input int t);
    if (rst) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (en) begin
      if (HAS_STACK && r) begin
        if (m_stack.size() == 0) m_unf = 1;
        else m_pc = m_stack.pop_back();
      end else if (HAS_STACK && c) begin
        if (m_stack.size() == DEPTH) m_ovf = 1;
        else begin
          m_stack.push_back((m_pc + 1) % (1 << WIDTH));
          m_pc = t;
        end
      end else if (c || j) begin
        m_pc = t;
      end else begin
        m_pc = (m_pc + 1) % (1 << WIDTH);
      end
    end
  endtask

  task automatic cycle(input string tag, input bit rst, input bit en, input bit j,
                       input bit c, input bit r, input int t);
    RESET  = rst;
    EN     = en;
    JUMP   = j;
    CALL   = c;
    RET    = r;
    TARGET = WIDTH'(t);
    @(posedge CLK);
    #1;
    model_step(rst, en, j, c, r, t);
    check_all(tag);
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b0; JUMP = 1'b0; CALL = 1'b0; RET = 1'b0; TARGET = '0;

    // Reset overrides an enabled CALL in the same cycle
    cycle("reset", 1, 1, 0, 1, 0, 8'h55);

    for (int i = 0; i < 3; i++) cycle("inc3", 0, 1, 0, 0, 0, 0);

    cycle("jump10", 0, 1, 1, 0, 0, 8'h10);
    cycle("call80", 0, 1, 0, 1, 0, 8'h80);
    cycle("ret11",  0, 1, 0, 0, 1, 0);

    cycle("reset2", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle("call20", 0, 1, 0, 1, 0, 8'h20);
    for (int i = 0; i < 4; i++) cycle("ret_lifo", 0, 1, 0, 0, 1, 0);

    cycle("reset3", 1, 0, 0, 0, 0, 0);
    cycle("ret_empty", 0, 1, 0, 0, 1, 0);
    cycle("inc_after_unf", 0, 1, 0, 0, 0, 0);

    cycle("jumpff", 0, 1, 1, 0, 0, 8'hFF);
    cycle("wrap", 0, 1, 0, 0, 0, 0);
    cycle("reset4", 1, 0, 0, 0, 0, 0);
    cycle("all_cmds", 0, 1, 1, 1, 1, 8'h77);

    cycle("en0_call", 0, 0, 0, 1, 0, 8'h33);
    cycle("en0_jump", 0, 0, 1, 0, 0, 8'h44);
    cycle("en0_ret",  0, 0, 0, 0, 1, 0);

    cycle("reset5", 1, 0, 0, 0, 0, 0);
    cycle("call_a", 0, 1, 0, 1, 0, 8'h40);
    cycle("call_b", 0, 1, 0, 1, 0, 8'h50);
    cycle("reset_mid", 1, 1, 0, 1, 0, 8'h60);
    cycle("ret_after_reset", 0, 1, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rst, en, j, c, r;
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 9) < 8);
      j   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 3) == 0);
      cycle("rand", rst, en, j, c, r, int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
